// File: rtl/pipeline_pkg.sv
// Shared definitions for the fetch front end: bus widths, reset defaults,
// fetch state encoding and the FIFO entry layout (address + byte).
package pipeline_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;

    localparam logic [ADDR_W-1:0] RESET_VECTOR = 16'h0000;
    localparam logic [DATA_W-1:0] NOP_OPCODE   = 8'h00;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        REDIRECT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {address, byte} entries.
// Flush has priority over push/pop. Push while full is accepted only
// together with a pop, so occupancy can stay at DEPTH without loss.
module fetch_fifo
    import pipeline_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       clr_n,
    input  logic                       push,
    input  fetch_entry_t               push_entry,
    input  logic                       pop,
    input  logic                       flush,
    output fetch_entry_t               head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    fetch_entry_t     mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Qualify push/pop against occupancy; a flush cancels both.
    always_comb begin
        do_push_s = 1'b0;
        do_pop_s  = 1'b0;
        if (flush) begin
            do_push_s = 1'b0;
            do_pop_s  = 1'b0;
        end else begin
            do_pop_s  = pop && (count_r != '0);
            do_push_s = push && ((count_r != FULL_CNT) || do_pop_s);
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents are only meaningful below count.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_entry;
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch front end: owns the fetch PC, issues one-cycle-latency ROM reads
// under a credit limit tied to FIFO depth, squashes the read in flight at
// a redirect, and presents one byte per cycle to pipeline stage 0.
module instruction_fetch #(
    parameter int          DEPTH        = 4,
    parameter logic [15:0] RESET_VECTOR = pipeline_pkg::RESET_VECTOR,
    parameter logic [7:0]  NOP_OPCODE   = pipeline_pkg::NOP_OPCODE
) (
    input  logic        ClockIn,
    input  logic        ResetIn_n,
    input  logic        Stall,
    input  logic        LoadPC,
    input  logic [15:0] LoadValue,
    output logic [15:0] MemAddr,
    output logic        MemRd,
    input  logic [7:0]  MemRdData,
    output logic [7:0]  MEMDATA,
    output logic        FetchValid,
    output logic [15:0] PCOut
);

    import pipeline_pkg::*;

    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int OUT_W = CNT_W + 2;

    fetch_state_e     state_r;
    fetch_state_e     state_nxt_s;
    logic [15:0]      pc_r;
    logic [15:0]      pc_nxt_s;
    logic [15:0]      mem_addr_r;
    logic [15:0]      mem_addr_nxt_s;
    logic             mem_rd_r;
    logic             mem_rd_nxt_s;
    logic             rd_pending_r;   // read data is on MemRdData this cycle
    logic [15:0]      rd_addr_r;      // address of that returning read
    logic             squash_r;       // returning read predates a redirect

    logic             fetch_valid_s;
    logic             pop_s;
    logic             ret_live_s;
    logic             push_s;
    logic [OUT_W-1:0] outstanding_s;
    logic             credit_ok_s;
    fetch_entry_t     push_entry_s;
    fetch_entry_t     head_s;
    logic [CNT_W-1:0] count_s;

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (ClockIn),
        .clr_n     (ResetIn_n),
        .push      (push_s),
        .push_entry(push_entry_s),
        .pop       (pop_s),
        .flush     (LoadPC),
        .head      (head_s),
        .count     (count_s)
    );

    assign push_entry_s = '{addr: rd_addr_r, data: MemRdData};

    // Consume/return handshakes and the outstanding-byte credit check.
    always_comb begin
        fetch_valid_s = (count_s != '0);
        pop_s         = fetch_valid_s & ~Stall & ~LoadPC;
        ret_live_s    = rd_pending_r & ~squash_r;
        push_s        = ret_live_s & ~LoadPC;
        outstanding_s = OUT_W'(count_s) + OUT_W'(ret_live_s) + OUT_W'(mem_rd_r);
        credit_ok_s   = (outstanding_s + OUT_W'(1'b1)) <= (OUT_W'(DEPTH) + OUT_W'(pop_s));
    end

    // Next state and next read request; a redirect always issues its target
    // immediately since the flush frees every credit.
    always_comb begin
        state_nxt_s    = state_r;
        pc_nxt_s       = pc_r;
        mem_addr_nxt_s = mem_addr_r;
        mem_rd_nxt_s   = 1'b0;
        if (LoadPC) begin
            state_nxt_s    = REDIRECT;
            mem_rd_nxt_s   = 1'b1;
            mem_addr_nxt_s = LoadValue;
            pc_nxt_s       = LoadValue + 16'd1;
        end else begin
            case (state_r)
                IDLE:     state_nxt_s = RUN;
                RUN:      state_nxt_s = RUN;
                REDIRECT: state_nxt_s = RUN;
                default:  state_nxt_s = IDLE;
            endcase
            if ((state_nxt_s == RUN) && credit_ok_s) begin
                mem_rd_nxt_s   = 1'b1;
                mem_addr_nxt_s = pc_r;
                pc_nxt_s       = pc_r + 16'd1;
            end else begin
                mem_rd_nxt_s   = 1'b0;
            end
        end
    end

    // State, PC and registered ROM request.
    always_ff @(posedge ClockIn or negedge ResetIn_n) begin
        if (!ResetIn_n) begin
            state_r    <= IDLE;
            pc_r       <= RESET_VECTOR;
            mem_addr_r <= RESET_VECTOR;
            mem_rd_r   <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            pc_r       <= pc_nxt_s;
            mem_addr_r <= mem_addr_nxt_s;
            mem_rd_r   <= mem_rd_nxt_s;
        end
    end

    // Track the read whose data arrives next cycle and whether it is stale.
    always_ff @(posedge ClockIn or negedge ResetIn_n) begin
        if (!ResetIn_n) begin
            rd_pending_r <= 1'b0;
            rd_addr_r    <= RESET_VECTOR;
            squash_r     <= 1'b0;
        end else begin
            rd_pending_r <= mem_rd_r;
            rd_addr_r    <= mem_addr_r;
            squash_r     <= LoadPC & mem_rd_r;
        end
    end

    // Stage-0 view: FIFO head, or NOP with the address expected next.
    always_comb begin
        FetchValid = fetch_valid_s;
        MEMDATA    = NOP_OPCODE;
        PCOut      = pc_r;
        if (fetch_valid_s) begin
            MEMDATA = head_s.data;
            PCOut   = head_s.addr;
        end else if (ret_live_s) begin
            PCOut   = rd_addr_r;
        end else if (mem_rd_r) begin
            PCOut   = mem_addr_r;
        end else begin
            PCOut   = pc_r;
        end
    end

    assign MemAddr = mem_addr_r;
    assign MemRd   = mem_rd_r;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a one-cycle-latency ROM model.
module tb_instruction_fetch;

    logic        ClockIn = 1'b0;
    logic        ResetIn_n;
    logic        Stall;
    logic        LoadPC;
    logic [15:0] LoadValue;
    logic [15:0] MemAddr;
    logic        MemRd;
    logic [7:0]  MemRdData;
    logic [7:0]  MEMDATA;
    logic        FetchValid;
    logic [15:0] PCOut;

    int tests_run    = 0;
    int tests_failed = 0;

    instruction_fetch #(
        .DEPTH       (4),
        .RESET_VECTOR(16'h0000),
        .NOP_OPCODE  (8'h00)
    ) dut (
        .ClockIn   (ClockIn),
        .ResetIn_n (ResetIn_n),
        .Stall     (Stall),
        .LoadPC    (LoadPC),
        .LoadValue (LoadValue),
        .MemAddr   (MemAddr),
        .MemRd     (MemRd),
        .MemRdData (MemRdData),
        .MEMDATA   (MEMDATA),
        .FetchValid(FetchValid),
        .PCOut     (PCOut)
    );

    always #5 ClockIn = ~ClockIn;

    // ROM contents: low address byte xor high byte, so ROM[n]=n for n<256.
    function automatic logic [7:0] rom(input logic [15:0] a);
        return a[7:0] ^ a[15:8];
    endfunction

    // Synchronous ROM: data valid the cycle after MemRd; junk otherwise.
    always @(posedge ClockIn) begin
        MemRdData <= MemRd ? rom(MemAddr) : 8'hEE;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ClockIn);
        #1;
    endtask

    task automatic expect_byte(input string tag, input logic [15:0] a);
        check({tag, ".valid"}, 32'(FetchValid), 32'd1);
        check({tag, ".pc"},    32'(PCOut),      32'(a));
        check({tag, ".data"},  32'(MEMDATA),    32'(rom(a)));
    endtask

    task automatic expect_empty(input string tag, input logic [15:0] a);
        check({tag, ".valid"}, 32'(FetchValid), 32'd0);
        check({tag, ".pc"},    32'(PCOut),      32'(a));
        check({tag, ".nop"},   32'(MEMDATA),    32'h00);
    endtask

    initial begin
        logic [15:0] a;
        ResetIn_n = 1'b0;
        Stall     = 1'b0;
        LoadPC    = 1'b0;
        LoadValue = 16'h0000;
        tick();
        tick();

        // 1) reset state, then streaming from the reset vector
        check("rst.memrd", 32'(MemRd), 32'd0);
        check("rst.addr",  32'(MemAddr), 32'h0000);
        expect_empty("rst", 16'h0000);
        ResetIn_n = 1'b1;
        tick();
        check("t1.c1.memrd", 32'(MemRd), 32'd1);
        check("t1.c1.addr",  32'(MemAddr), 32'h0000);
        expect_empty("t1.c1", 16'h0000);
        tick();
        check("t1.c2.addr", 32'(MemAddr), 32'h0001);
        expect_empty("t1.c2", 16'h0000);
        for (int i = 0; i < 6; i++) begin
            tick();
            expect_byte("t1.stream", 16'(i));
            check("t1.addr", 32'(MemAddr), 32'(i + 2));
        end

        // 2) stall six cycles: head held, issue stops once four are outstanding
        Stall = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            expect_byte("t2.hold", 16'd5);
            check("t2.memrd", 32'(MemRd), (i == 0) ? 32'd1 : 32'd0);
        end
        Stall = 1'b0;
        for (int i = 6; i < 14; i++) begin
            tick();
            expect_byte("t2.resume", 16'(i));
        end

        // 3) fill, free one slot (3 bytes held, one read in flight), redirect
        Stall = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            expect_byte("t3.fill", 16'd13);
        end
        Stall = 1'b0;
        tick();
        expect_byte("t3.pre", 16'd14);
        check("t3.pre.memrd", 32'(MemRd), 32'd1);
        check("t3.pre.addr",  32'(MemAddr), 32'd17);
        LoadPC    = 1'b1;
        LoadValue = 16'h1234;
        tick();
        LoadPC = 1'b0;
        check("t3.r1.addr",  32'(MemAddr), 32'h1234);
        check("t3.r1.memrd", 32'(MemRd), 32'd1);
        expect_empty("t3.r1", 16'h1234);
        tick();
        check("t3.r2.addr", 32'(MemAddr), 32'h1235);
        expect_empty("t3.r2", 16'h1234);
        tick();
        expect_byte("t3.new0", 16'h1234);
        tick();
        expect_byte("t3.new1", 16'h1235);
        tick();
        expect_byte("t3.new2", 16'h1236);

        // 4) PC wrap at 16'hFFFF
        LoadPC    = 1'b1;
        LoadValue = 16'hFFFE;
        tick();
        LoadPC = 1'b0;
        expect_empty("t4.r1", 16'hFFFE);
        tick();
        expect_empty("t4.r2", 16'hFFFE);
        a = 16'hFFFE;
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_byte("t4.wrap", a);
            a = a + 16'd1;
        end

        // 5) redirect with stall, then a second redirect in the REDIRECT cycle
        LoadPC    = 1'b1;
        Stall     = 1'b1;
        LoadValue = 16'h4000;
        tick();
        check("t5.r1.addr", 32'(MemAddr), 32'h4000);
        expect_empty("t5.r1", 16'h4000);
        LoadValue = 16'h5678;
        Stall     = 1'b0;
        tick();
        LoadPC = 1'b0;
        check("t5.r2.addr", 32'(MemAddr), 32'h5678);
        expect_empty("t5.r2", 16'h5678);
        tick();
        expect_empty("t5.r3", 16'h5678);
        tick();
        expect_byte("t5.new0", 16'h5678);
        tick();
        expect_byte("t5.new1", 16'h5679);

        // 6) asynchronous reset between edges, then restart
        #2;
        ResetIn_n = 1'b0;
        #1;
        check("t6.rst.memrd", 32'(MemRd), 32'd0);
        check("t6.rst.addr",  32'(MemAddr), 32'h0000);
        expect_empty("t6.rst", 16'h0000);
        tick();
        expect_empty("t6.hold", 16'h0000);
        ResetIn_n = 1'b1;
        tick();
        check("t6.c1.memrd", 32'(MemRd), 32'd1);
        check("t6.c1.addr",  32'(MemAddr), 32'h0000);
        tick();
        expect_empty("t6.c2", 16'h0000);
        tick();
        expect_byte("t6.b0", 16'h0000);
        tick();
        expect_byte("t6.b1", 16'h0001);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
